booth_mult_seq: RTL and testbench

- Sequential radix-2 Booth signed multiplier that produces one n-bit by n-bit two's-complement product in n iteration cycles.
- Feeds and consumes the team's add/subtract stage. It instantiates add_subBar with n set to n+1 and drives add_sub each cycle: 0 = add, 1 = subtract.
- It captures s from that stage back into its accumulator.
- It sits between the operand issue logic and the result sink of the arithmetic datapath.

---
 rtl/booth_mult_seq.sv | 119 +++++++++++
 tb/tb_booth_mult_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier: one n x n two's-complement product
// every n+2 cycles, using an (n+1)-bit add/subtract stage for the accumulator.

module add_subBar #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         add_sub,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         OverflowSign
);
  logic [n-1:0] b_x;

  // Subtraction is a + ~b + 1: invert b and feed add_sub in as the carry.
  assign b_x = b ^ {n{add_sub}};
  assign {cout, s} = {1'b0, a} + {1'b0, b_x} + {{n{1'b0}}, add_sub};
  assign OverflowSign = (a[n-1] == b_x[n-1]) && (s[n-1] != a[n-1]);
endmodule

// state | meaning
// IDLE  | waiting for start; product holds the last result
// CALC  | one Booth add/sub + arithmetic shift per cycle, n cycles
// DONE  | product valid, done pulses for one cycle
module booth_mult_seq #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product
);
  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [n:0]    m_r;
  logic [n:0]    acc;
  logic [n-1:0]  q;
  logic          q_m1;
  logic [CW-1:0] cnt;

  logic          add_sub;
  logic [n:0]    r_sum;
  logic [n:0]    r_sel;
  logic [n:0]    acc_nx;
  logic [n-1:0]  q_nx;

  // {q[0], q_m1} = 10 subtracts, 01 adds, so q[0] alone picks the operation.
  assign add_sub = q[0];
  assign r_sel   = (q[0] ^ q_m1) ? r_sum : acc;
  assign acc_nx  = {r_sel[n], r_sel[n:1]};
  assign q_nx    = {r_sel[0], q[n-1:1]};

  add_subBar #(.n(n + 1)) u_add_sub (
    .a            (acc),
    .b            (m_r),
    .add_sub      (add_sub),
    .s            (r_sum),
    .cout         (),
    .OverflowSign ()
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m_r     <= '0;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_r   <= {a[n-1], a};
            acc   <= '0;
            q     <= b;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_nx;
          q    <= q_nx;
          q_m1 <= q[0];
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(n - 1)) begin
            product <= {acc_nx[n-1:0], q_nx};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at n=4 and n=8: directed table, handshake corner
// cases, exhaustive n=4 and random n=8, all checked through expected-product queues.

module tb_booth_mult_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;
  int acc4 = 0, dn4 = 0, acc8 = 0, dn8 = 0;
  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  booth_mult_seq #(.n(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  booth_mult_seq #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y);
    int p;
    p = $signed(x) * $signed(y);
    return p[7:0];
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = $signed(x) * $signed(y);
    return p[15:0];
  endfunction

  // Scoreboards: every done pops one expected product.
  always @(negedge clk) begin
    if (!rst && done4 === 1'b1) begin
      dn4++;
      chk("overlap4", {31'd0, busy4}, 0);
      chk("sb4_nonempty", {31'd0, q4.size() != 0}, 1);
      if (q4.size() != 0) chk("product4", {24'd0, prod4}, {24'd0, q4.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && done8 === 1'b1) begin
      dn8++;
      chk("overlap8", {31'd0, busy8}, 0);
      chk("sb8_nonempty", {31'd0, q8.size() != 0}, 1);
      if (q8.size() != 0) chk("product8", {16'd0, prod8}, {16'd0, q8.pop_front()});
    end
  end

  task automatic accept4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
    @(negedge clk);
    a4 = x; b4 = y; start4 = 1'b1;
    @(posedge clk);
    q4.push_back(exp);
    acc4++;
    #1 start4 = 1'b0;
  endtask

  // Called right after the accept edge; returns at the negedge of the DONE cycle.
  task automatic track4(input bit scramble, input string tag);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {30'd0, busy4, done4}, 2);
      if (scramble) begin a4 = 4'($urandom_range(15)); b4 = 4'($urandom_range(15)); end
    end
    @(negedge clk);
    chk({tag, "_done"}, {30'd0, busy4, done4}, 1);
    if (scramble) begin a4 = 4'($urandom_range(15)); b4 = 4'($urandom_range(15)); end
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk);
    q8.push_back(ref8(x, y));
    acc8++;
    #1 start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("busy8", {31'd0, busy8}, 1);
      a8 = 8'($urandom_range(255)); b8 = 8'($urandom_range(255));
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd3,  4'hE, 8'hFA};
    vecs[1] = '{4'h8,  4'h8, 8'h40};
    vecs[2] = '{4'h8,  4'd7, 8'hC8};
    vecs[3] = '{4'd7,  4'd7, 8'h31};
    vecs[4] = '{4'd0,  4'd5, 8'h00};
    vecs[5] = '{4'd5,  4'd0, 8'h00};
    vecs[6] = '{4'hF,  4'hF, 8'h01};
    vecs[7] = '{4'h8,  4'd1, 8'hF8};
    vecs[8] = '{4'hD,  4'd4, 8'hF4};
    vecs[9] = '{4'd6,  4'd5, 8'h1E};

    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state4", {22'd0, busy4, done4, prod4}, 0);
    chk("rst_state8", {14'd0, busy8, done8, prod8}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      accept4(vecs[i].a, vecs[i].b, vecs[i].exp);
      track4(1'b0, "vec");
      @(negedge clk);
      chk("hold_idle", {24'd0, prod4}, {24'd0, vecs[i].exp});
      @(negedge clk);
      chk("hold_idle2", {22'd0, busy4, done4, prod4}, {24'd0, vecs[i].exp});
    end

    // start held high and operands changing through CALC and DONE
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    @(posedge clk);
    q4.push_back(8'h0F); acc4++;
    track4(1'b1, "held1");
    @(negedge clk);
    chk("held_idle", {30'd0, busy4, done4}, 0);
    a4 = 4'd2; b4 = 4'hD;
    @(posedge clk);
    q4.push_back(8'hFA); acc4++;
    #1 start4 = 1'b0;
    track4(1'b0, "held2");

    // reset in the second CALC cycle
    accept4(4'd6, 4'd5, 8'h1E);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midcalc_rst", {22'd0, busy4, done4, prod4}, 0);
    rst = 1'b0;
    q4.delete();
    acc4--;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("no_done_after_rst", {31'd0, done4}, 0);
    end
    accept4(4'd2, 4'd2, 8'h04);
    track4(1'b0, "post_rst");

    // exhaustive n=4, back-to-back
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        accept4(4'(x), 4'(y), ref4(4'(x), 4'(y)));
        track4(1'b1, "exh");
      end

    // n=8 corners then random, back-to-back
    run8(8'h80, 8'h80);
    run8(8'h80, 8'h7F);
    run8(8'h7F, 8'h7F);
    run8(8'h00, 8'h9C);
    run8(8'hFF, 8'h01);
    for (int i = 0; i < 2000; i++)
      run8(8'($urandom_range(255)), 8'($urandom_range(255)));

    repeat (4) @(negedge clk);
    chk("done_count4", dn4, acc4);
    chk("done_count8", dn8, acc8);
    chk("sb4_drained", q4.size(), 0);
    chk("sb8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
